// File: rtl/display_pkg.sv
// Shared types and constants for the display character scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_CLEAR   = 2'd3
    } sched_state_e;

    // Display raster geometry in pixel_clken ticks
    localparam int FRAME_W = 456;
    localparam int FRAME_H = 263;

    // One full frame of ticks guarantees the whole screen is wiped
    localparam int CLR_TICKS_DFLT = FRAME_W * FRAME_H;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous host character FIFO with registered pointers and occupancy.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module sched_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     sys_clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [LW-1:0] wr_ptr_q;
    logic [LW-1:0] rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign full_o     = (level_o == LW'(DEPTH));
    assign empty_o    = (level_o == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset empties the FIFO
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + LW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + LW'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge sys_clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/display_char_sched.sv
// Arbitrates CPU and host characters (plus clear-screen) onto one display write port.
// Latency: a pending character is offered the cycle after IDLE sees disp_ready=1.
// Backpressure: CPU via cpu_busy, host via host_ready; host path exists only with DISPLAY_SCHED_HOST_EN.
module display_char_sched
    import display_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CLR_TICKS  = CLR_TICKS_DFLT
) (
    input  logic                         reset,
    input  logic                         sys_clock,
    input  logic                         pixel_clken,
    input  logic                         cpu_clken,
    input  logic                         cpu_wr,
    input  logic [7:0]                   cpu_data,
    output logic                         cpu_busy,
    input  logic                         host_valid,
    input  logic [7:0]                   host_data,
    output logic                         host_ready,
    input  logic                         clr_req,
    input  logic                         disp_ready,
    output logic                         disp_w_en,
    output logic                         disp_address,
    output logic [7:0]                   disp_din,
    output logic                         disp_clr_screen,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int CW = $clog2(CLR_TICKS + 1);

    sched_state_e state_q, state_d;
    logic         cpu_busy_q, cpu_busy_d;
    logic [7:0]   cpu_chr_q;
    logic         cpu_take;
    logic         clr_pend_q, clr_pend_d;
    logic         rr_cpu_q, rr_cpu_d;     // CPU has priority on the next contested grant
    logic         gnt_cpu_q, gnt_cpu_d;   // owner of the character being issued
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic         fifo_pop;
    logic [7:0]   fifo_head;
    logic         host_pend;

`ifdef DISPLAY_SCHED_HOST_EN
    logic fifo_full;
    logic fifo_empty;

    sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .sys_clock  (sys_clock),
        .reset      (reset),
        .push_i     (host_valid),
        .push_dat_i (host_data),
        .pop_i      (fifo_pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    assign host_ready = !fifo_full;
    assign host_pend  = !fifo_empty;
`else
    logic unused_host;

    assign host_ready  = 1'b0;
    assign fifo_level  = '0;
    assign fifo_head   = 8'h00;
    assign host_pend   = 1'b0;
    assign unused_host = ^{host_valid, host_data, fifo_pop};
`endif

    // Busy is sampled before update, so a write on the releasing cycle is lost
    assign cpu_take = cpu_wr && !cpu_busy_q;

    // Next-state, grant, clear counter and source release decisions
    always_comb begin
        state_d    = state_q;
        cpu_busy_d = cpu_busy_q;
        clr_pend_d = clr_pend_q | clr_req;
        rr_cpu_d   = rr_cpu_q;
        gnt_cpu_d  = gnt_cpu_q;
        clr_cnt_d  = clr_cnt_q;
        fifo_pop   = 1'b0;

        if (cpu_take) cpu_busy_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (clr_pend_q || clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                    clr_cnt_d  = '0;
                end else if (disp_ready && (cpu_busy_q || host_pend)) begin
                    state_d = ST_ISSUE;
                    if (cpu_busy_q && (!host_pend || rr_cpu_q)) begin
                        gnt_cpu_d = 1'b1;
                        rr_cpu_d  = 1'b0;
                    end else begin
                        gnt_cpu_d = 1'b0;
                        rr_cpu_d  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // Display acknowledges by dropping ready on a pixel tick
                if (pixel_clken && !disp_ready) begin
                    state_d = ST_RELEASE;
                    if (gnt_cpu_q) cpu_busy_d = 1'b0;
                    else           fifo_pop   = 1'b1;
                end
            end
            ST_RELEASE: begin
                // Waiting for a CPU-idle pixel tick lets the display clear char_seen
                if (pixel_clken && !cpu_clken) state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                clr_pend_d = 1'b0;
                if (clr_req) begin
                    clr_cnt_d = '0;
                end else if (pixel_clken) begin
                    if (clr_cnt_q == CW'(CLR_TICKS - 1)) begin
                        state_d   = ST_IDLE;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers; reset drops any in-flight character or clear
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cpu_busy_q <= 1'b0;
            clr_pend_q <= 1'b0;
            rr_cpu_q   <= 1'b1;
            gnt_cpu_q  <= 1'b1;
            clr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cpu_busy_q <= cpu_busy_d;
            clr_pend_q <= clr_pend_d;
            rr_cpu_q   <= rr_cpu_d;
            gnt_cpu_q  <= gnt_cpu_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    // CPU holding register, loaded only when a write is accepted
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset)         cpu_chr_q <= 8'h00;
        else if (cpu_take) cpu_chr_q <= cpu_data;
    end

    assign cpu_busy        = cpu_busy_q;
    assign disp_w_en       = (state_q == ST_ISSUE);
    assign disp_clr_screen = (state_q == ST_CLEAR);
    assign disp_address    = 1'b0;
    assign disp_din        = disp_w_en ? (gnt_cpu_q ? cpu_chr_q : fifo_head) : 8'h00;

endmodule

// File: tb/tb_display_char_sched.sv
// Self-checking bench for display_char_sched against a queue-based arbitration model.
// Latency: n/a.
// Backpressure: bench acts as the display, dropping disp_ready to acknowledge writes.
module tb_display_char_sched;
    localparam int DEPTH = 8;
    localparam int CLR   = 12;
`ifdef DISPLAY_SCHED_HOST_EN
    localparam bit HOST_EN = 1'b1;
`else
    localparam bit HOST_EN = 1'b0;
`endif

    logic                    reset, sys_clock, pixel_clken, cpu_clken, cpu_wr;
    logic [7:0]              cpu_data, host_data, disp_din;
    logic                    cpu_busy, host_valid, host_ready, clr_req, disp_ready;
    logic                    disp_w_en, disp_address, disp_clr_screen;
    logic [$clog2(DEPTH):0]  fifo_level;

    int total, bad;

    // Reference model: pending CPU char, host queue, who wins a tie next
    bit         m_cpu_pend;
    logic [7:0] m_cpu_chr;
    logic [7:0] m_hq[$];
    bit         m_rr_cpu;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    display_char_sched #(.FIFO_DEPTH(DEPTH), .CLR_TICKS(CLR)) dut (
        .reset(reset), .sys_clock(sys_clock), .pixel_clken(pixel_clken), .cpu_clken(cpu_clken),
        .cpu_wr(cpu_wr), .cpu_data(cpu_data), .cpu_busy(cpu_busy),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .clr_req(clr_req), .disp_ready(disp_ready), .disp_w_en(disp_w_en),
        .disp_address(disp_address), .disp_din(disp_din),
        .disp_clr_screen(disp_clr_screen), .fifo_level(fifo_level)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    // One stimulus cycle with the display held not-ready; model tracks acceptance
    task automatic drive_cycle(input bit wr, input logic [7:0] cd, input bit hv, input logic [7:0] hd);
        bit acc_cpu, acc_host;
        cpu_wr = wr; cpu_data = cd; host_valid = hv; host_data = hd;
        pixel_clken = 1'($urandom_range(0, 1));
        cpu_clken   = 1'($urandom_range(0, 1));
        acc_cpu  = wr && !m_cpu_pend;
        acc_host = HOST_EN && hv && (m_hq.size() < DEPTH);
        step();
        cpu_wr = 1'b0; host_valid = 1'b0;
        if (acc_cpu) begin m_cpu_pend = 1'b1; m_cpu_chr = cd; end
        if (acc_host) m_hq.push_back(hd);
        check("busy", cpu_busy, m_cpu_pend);
        check("level", fifo_level, m_hq.size());
        check("host_ready", host_ready, HOST_EN && (m_hq.size() < DEPTH));
    endtask

    // Let the display consume everything pending and compare delivery order
    task automatic drain();
        int cyc;
        logic [7:0] cur;
        exp_q = {};
        while (m_cpu_pend || m_hq.size() > 0) begin
            if (m_cpu_pend && (m_hq.size() == 0 || m_rr_cpu)) begin
                exp_q.push_back(m_cpu_chr); m_cpu_pend = 1'b0; m_rr_cpu = 1'b0;
            end else begin
                exp_q.push_back(m_hq.pop_front()); m_rr_cpu = 1'b1;
            end
        end
        got_q = {};
        cur = 8'h00;
        cyc = 0;
        disp_ready = 1'b1;
        while (got_q.size() < exp_q.size() && cyc < 2000) begin
            pixel_clken = 1'($urandom_range(0, 1));
            cpu_clken   = 1'($urandom_range(0, 1));
            step();
            cyc++;
            check("addr", disp_address, 1'b0);
            if (disp_w_en) begin
                if (disp_ready) begin
                    got_q.push_back(disp_din); cur = disp_din; disp_ready = 1'b0;
                end else begin
                    check("din_hold", disp_din, cur);
                end
            end else begin
                check("din_idle", disp_din, 8'h00);
                if (!disp_ready && $urandom_range(0, 2) == 0) disp_ready = 1'b1;
            end
        end
        disp_ready = 1'b0; pixel_clken = 1'b1; cpu_clken = 1'b0;
        repeat (4) step();
        check("drain_cnt", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("order", got_q[i], exp_q[i]);
        check("drain_wen", disp_w_en, 1'b0);
        check("drain_busy", cpu_busy, 1'b0);
        check("drain_level", fifo_level, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, cyc;
        bit restarted;
        total = 0; bad = 0;
        m_cpu_pend = 1'b0; m_cpu_chr = 8'h00; m_rr_cpu = 1'b1; m_hq = {};
        reset = 1'b1; pixel_clken = 1'b0; cpu_clken = 1'b0; cpu_wr = 1'b0; cpu_data = 8'h00;
        host_valid = 1'b0; host_data = 8'h00; clr_req = 1'b0; disp_ready = 1'b0;
        repeat (3) @(posedge sys_clock);
        #1;
        check("rst_wen", disp_w_en, 1'b0);
        check("rst_din", disp_din, 8'h00);
        check("rst_clr", disp_clr_screen, 1'b0);
        check("rst_busy", cpu_busy, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_hrdy", host_ready, HOST_EN);
        check("rst_addr", disp_address, 1'b0);
        reset = 1'b0;
        step();

        // Fill the FIFO past capacity; ninth push dropped
        for (int i = 0; i < 9; i++) drive_cycle(1'b0, 8'h00, 1'b1, 8'h41 + 8'(i));
        drain();
        // CPU and host together, then round-robin follow-ups
        drive_cycle(1'b1, 8'hB1, 1'b1, 8'h42); drain();
        drive_cycle(1'b1, 8'hB2, 1'b1, 8'h43); drain();
        drive_cycle(1'b1, 8'hB3, 1'b0, 8'h00); drain();
        drive_cycle(1'b1, 8'hB4, 1'b1, 8'h44); drain();
        // Randomised batches, including dropped CPU writes while busy
        for (int b = 0; b < 20; b++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++)
                drive_cycle(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 1) == 1), 8'($urandom));
            drain();
        end

        // Single CPU character handshake
        disp_ready = 1'b1; pixel_clken = 1'b0; cpu_clken = 1'b0;
        cpu_wr = 1'b1; cpu_data = 8'hC1; step(); cpu_wr = 1'b0;
        check("c1_busy", cpu_busy, 1'b1);
        check("c1_wen_early", disp_w_en, 1'b0);
        step();
        check("c1_wen", disp_w_en, 1'b1);
        check("c1_din", disp_din, 8'hC1);
        pixel_clken = 1'b1;
        repeat (3) begin step(); check("c1_hold_wen", disp_w_en, 1'b1); check("c1_hold_din", disp_din, 8'hC1); end
        disp_ready = 1'b0; pixel_clken = 1'b0;
        step();
        check("c1_nopix_wen", disp_w_en, 1'b1);
        // Write on the releasing cycle must be lost
        pixel_clken = 1'b1; cpu_wr = 1'b1; cpu_data = 8'h55; step(); cpu_wr = 1'b0;
        check("c1_done_wen", disp_w_en, 1'b0);
        check("c1_done_din", disp_din, 8'h00);
        check("c1_busy_clr", cpu_busy, 1'b0);

        // RELEASE holds while cpu_clken stays high on pixel ticks
        cpu_clken = 1'b1; disp_ready = 1'b1; cpu_wr = 1'b1; cpu_data = 8'hC2; step(); cpu_wr = 1'b0;
        check("c2_busy", cpu_busy, 1'b1);
        repeat (4) begin step(); check("rel_hold", disp_w_en, 1'b0); end
        cpu_clken = 1'b0; step();
        check("rel_exit", disp_w_en, 1'b0);
        cpu_clken = 1'b1; step();
        check("c2_wen", disp_w_en, 1'b1);
        check("c2_din", disp_din, 8'hC2);
        disp_ready = 1'b0; pixel_clken = 1'b1; step();
        cpu_clken = 1'b0; step();
        check("c2_busy_clr", cpu_busy, 1'b0);

        // Clear requested mid-character, served after it, with a restart
        disp_ready = 1'b1; pixel_clken = 1'b0;
        cpu_wr = 1'b1; cpu_data = 8'hD2; step(); cpu_wr = 1'b0;
        step();
        check("d2_wen", disp_w_en, 1'b1);
        clr_req = 1'b1; step(); clr_req = 1'b0;
        check("clr_issue_wen", disp_w_en, 1'b1);
        check("clr_issue_clr", disp_clr_screen, 1'b0);
        disp_ready = 1'b0; pixel_clken = 1'b1; cpu_clken = 1'b0; step();
        check("d2_rel_wen", disp_w_en, 1'b0);
        cpu_wr = 1'b1; cpu_data = 8'hD3; disp_ready = 1'b1; step(); cpu_wr = 1'b0;
        check("clr_not_yet", disp_clr_screen, 1'b0);
        step();
        check("clr_start", disp_clr_screen, 1'b1);
        check("clr_start_wen", disp_w_en, 1'b0);
        ticks = 0; cyc = 0; restarted = 1'b0;
        while (disp_clr_screen && cyc < 1000) begin
            if (ticks == 5 && !restarted) begin
                pixel_clken = 1'b0; clr_req = 1'b1; restarted = 1'b1;
            end else begin
                pixel_clken = 1'($urandom_range(0, 1));
            end
            if (pixel_clken) ticks++;
            step();
            clr_req = 1'b0;
            cyc++;
            if (disp_w_en) check("clr_wen", disp_w_en, 1'b0);
        end
        check("clr_ticks", ticks, 5 + CLR);
        step();
        check("d3_wen", disp_w_en, 1'b1);
        check("d3_din", disp_din, 8'hD3);
        check("clr_level", fifo_level, 0);
        disp_ready = 1'b0; pixel_clken = 1'b1; step();
        cpu_clken = 1'b0; step();

        // Reset in the middle of an issue
        cpu_wr = 1'b1; cpu_data = 8'hE1; host_valid = 1'b1; host_data = 8'h61; step();
        cpu_wr = 1'b0; host_data = 8'h62; step(); host_valid = 1'b0;
        disp_ready = 1'b1; step();
        check("e1_wen", disp_w_en, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_wen", disp_w_en, 1'b0);
        check("mid_rst_busy", cpu_busy, 1'b0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_din", disp_din, 8'h00);
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pixel_clken = 1'($urandom_range(0, 1));
            step();
            check("post_rst_wen", disp_w_en, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
